// File: rtl/ifq.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Optional same-cycle bypass on an empty queue is enabled by defining IFQ_BYPASS_EN.
module ifq #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_pc,
    input  logic [W-1:0]             in_instr,
    output logic                     in_ready,
    output logic                     almost_full,
    output logic                     out_valid,
    output logic [W-1:0]             out_pc,
    output logic [W-1:0]             out_instr,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(DEPTH - 1);

    logic [W-1:0]  pcMem    [DEPTH];
    logic [W-1:0]  instrMem [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          empty;
    logic          storeFire;
    logic          popFire;
    logic [W-1:0]  headPc;
    logic [W-1:0]  headInstr;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full        = (count_q == FULL_COUNT);
        empty       = (count_q == '0);
        in_ready    = !full;
        almost_full = (count_q >= AF_COUNT);
        count       = count_q;
        headPc      = empty ? '0 : pcMem[rdPtr_q];
        headInstr   = empty ? '0 : instrMem[rdPtr_q];
    end

`ifdef IFQ_BYPASS_EN
    // An empty queue forwards the fetch pair straight to decode; it is only
    // written into storage when decode does not take it in the same cycle.
    logic bypassActive;

    always_comb begin
        bypassActive = empty && !flush && in_valid;
        popFire      = !flush && !empty && out_ready;
        storeFire    = !flush && in_valid && !full && !(bypassActive && out_ready);
        out_valid    = !empty || bypassActive;
        out_pc       = bypassActive ? in_pc    : headPc;
        out_instr    = bypassActive ? in_instr : headInstr;
    end
`else
    always_comb begin
        popFire   = !flush && !empty && out_ready;
        storeFire = !flush && in_valid && !full;
        out_valid = !empty;
        out_pc    = headPc;
        out_instr = headInstr;
    end
`endif

    always_comb begin
        wrPtr_d = storeFire ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = popFire   ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        unique case ({storeFire, popFire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; empty-queue outputs are forced to zero instead.
    always_ff @(posedge clk) begin
        if (storeFire) begin
            pcMem[wrPtr_q]    <= in_pc;
            instrMem[wrPtr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ifq;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_pc = '0;
    logic [W-1:0]  in_instr = '0;
    logic          in_ready;
    logic          almost_full;
    logic          out_valid;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_instr;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } entry_t;

    entry_t mq[$];
    int total = 0;
    int bad   = 0;

    ifq #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_ready(in_ready), .almost_full(almost_full),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] instrOf(input logic [W-1:0] pc);
        return pc ^ 32'hC0DE_0013;
    endfunction

    task automatic setIn(input logic v, input logic [W-1:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instrOf(pc);
        out_ready = ordy;
        flush     = fl;
    endtask

    // Reference model: queue semantics applied to the inputs present at the edge.
    task automatic modelEdge();
        int n;
        bit push;
        n = mq.size();
        push = in_valid && (n != DEPTH);
        if (rst || flush) begin
            mq.delete();
        end else begin
`ifdef IFQ_BYPASS_EN
            if (n == 0) begin
                if (push && !out_ready) mq.push_back('{in_pc, in_instr});
            end else begin
                if (out_ready) void'(mq.pop_front());
                if (push) mq.push_back('{in_pc, in_instr});
            end
`else
            if (n != 0 && out_ready) void'(mq.pop_front());
            if (push) mq.push_back('{in_pc, in_instr});
`endif
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        mq.delete();
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_almost_full: got %b expected 0", almost_full); end
        total++; if (out_pc !== '0) begin bad++; $display("[TB] FAIL reset_out_pc: got %0h expected 0", out_pc); end
        total++; if (out_instr !== '0) begin bad++; $display("[TB] FAIL reset_out_instr: got %0h expected 0", out_instr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] pc;
        for (int i = 0; i < 4; i++) begin
            pc = W'(i * 4);
            setIn(1'b1, pc, 1'b0, 1'b0);
            tick();
            total++; if (count !== CW'(i + 1)) begin bad++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i + 1); end
            total++; if (almost_full !== (i + 1 >= 3)) begin bad++; $display("[TB] FAIL fill_almost_full: got %b expected %b at count %0d", almost_full, (i + 1 >= 3), i + 1); end
            total++; if (in_ready !== (i + 1 != 4)) begin bad++; $display("[TB] FAIL fill_in_ready: got %b expected %b", in_ready, (i + 1 != 4)); end
        end
        setIn(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pc = W'(i * 4);
            #1;
            total++; if (out_valid !== 1'b1 || out_pc !== pc || out_instr !== instrOf(pc)) begin bad++; $display("[TB] FAIL drain_head: got v=%b pc=%0h expected v=1 pc=%0h", out_valid, out_pc, pc); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || count !== '0 || out_pc !== '0) begin bad++; $display("[TB] FAIL drain_empty: got v=%b count=%0d pc=%0h expected v=0 count=0 pc=0", out_valid, count, out_pc); end
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] expPc;
        setIn(1'b1, 32'h100, 1'b0, 1'b0); tick();
        setIn(1'b1, 32'h104, 1'b0, 1'b0); tick();
        for (int k = 0; k < 10; k++) begin
            expPc = 32'h100 + W'(4 * k);
            setIn(1'b1, 32'h108 + W'(4 * k), 1'b1, 1'b0);
            #1;
            total++; if (out_pc !== expPc) begin bad++; $display("[TB] FAIL b2b_order: got %0h expected %0h", out_pc, expPc); end
            tick();
            total++; if (count !== CW'(2)) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 2", count); end
        end
        setIn(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expPc = 32'h128 + W'(4 * k);
            total++; if (out_valid !== 1'b1 || out_pc !== expPc) begin bad++; $display("[TB] FAIL b2b_drain: got v=%b pc=%0h expected v=1 pc=%0h", out_valid, out_pc, expPc); end
            tick();
        end
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            setIn(1'b1, 32'h300 + W'(4 * i), 1'b0, 1'b0);
            tick();
        end
        total++; if (count !== CW'(4) || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_state: got count=%0d in_ready=%b expected count=4 in_ready=0", count, in_ready); end
        setIn(1'b1, 32'h400, 1'b1, 1'b0);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_indep: got %b expected 0", in_ready); end
        tick();
        total++; if (count !== CW'(3) || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_pop: got count=%0d in_ready=%b expected count=3 in_ready=1", count, in_ready); end
        setIn(1'b0, '0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            total++; if (out_pc !== 32'h300 + W'(4 * i)) begin bad++; $display("[TB] FAIL full_drain: got %0h expected %0h", out_pc, 32'h300 + W'(4 * i)); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_no_push: got out_valid=%b expected 0", out_valid); end
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            setIn(1'b1, 32'h500 + W'(4 * i), 1'b0, 1'b0);
            tick();
        end
        total++; if (count !== CW'(3)) begin bad++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", count); end
        setIn(1'b1, 32'h600, 1'b1, 1'b1);
        tick();
        total++; if (count !== '0 || out_valid !== 1'b0 || out_pc !== '0) begin bad++; $display("[TB] FAIL flush_clear: got count=%0d v=%b pc=%0h expected 0 0 0", count, out_valid, out_pc); end
        setIn(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        total++; if (count !== CW'(1) || out_valid !== 1'b1 || out_pc !== 32'h200) begin bad++; $display("[TB] FAIL flush_repush: got count=%0d v=%b pc=%0h expected 1 1 200", count, out_valid, out_pc); end
        setIn(1'b0, '0, 1'b1, 1'b0);
        tick();
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        setIn(1'b1, 32'h700, 1'b0, 1'b0); tick();
        setIn(1'b1, 32'h704, 1'b0, 1'b0); tick();
        setIn(1'b0, '0, 1'b0, 1'b0);
        total++; if (count !== CW'(2)) begin bad++; $display("[TB] FAIL arst_pre_count: got %0d expected 2", count); end
        #3 rst = 1'b1;
        #1;
        mq.delete();
        total++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== '0) begin bad++; $display("[TB] FAIL arst_clear: got count=%0d v=%b rdy=%b pc=%0h expected 0 0 1 0", count, out_valid, in_ready, out_pc); end
        #2 rst = 1'b0;
        setIn(1'b1, 32'h7F0, 1'b0, 1'b0);
        tick();
        total++; if (count !== CW'(1) || out_pc !== 32'h7F0) begin bad++; $display("[TB] FAIL arst_restart: got count=%0d pc=%0h expected 1 7f0", count, out_pc); end
        setIn(1'b0, '0, 1'b1, 1'b0);
        tick();
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_empty_push();
        setIn(1'b1, 32'h40, 1'b1, 1'b0);
        #1;
`ifdef IFQ_BYPASS_EN
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++; $display("[TB] FAIL bypass_same_cycle: got v=%b pc=%0h expected 1 40", out_valid, out_pc); end
        tick();
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL bypass_count: got %0d expected 0", count); end
`else
        total++; if (out_valid !== 1'b0 || out_pc !== '0) begin bad++; $display("[TB] FAIL nobypass_same_cycle: got v=%b pc=%0h expected 0 0", out_valid, out_pc); end
        tick();
        total++; if (count !== CW'(1) || out_pc !== 32'h40) begin bad++; $display("[TB] FAIL nobypass_latency: got count=%0d pc=%0h expected 1 40", count, out_pc); end
`endif
        setIn(1'b0, '0, 1'b1, 1'b0);
        tick();
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n;
        logic          expValid;
        logic [W-1:0]  expPc;
        logic [W-1:0]  expInstr;
        for (int c = 0; c < 500; c++) begin
            setIn(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            #1;
            n = mq.size();
            expValid = (n != 0);
            expPc    = (n != 0) ? mq[0].pc : '0;
            expInstr = (n != 0) ? mq[0].instr : '0;
`ifdef IFQ_BYPASS_EN
            if (n == 0 && !flush) begin
                expValid = in_valid;
                expPc    = in_valid ? in_pc : '0;
                expInstr = in_valid ? in_instr : '0;
            end
`endif
            total++; if (count !== CW'(n)) begin bad++; $display("[TB] FAIL rand_count: cycle %0d got %0d expected %0d", c, count, n); end
            total++; if (in_ready !== (n != DEPTH)) begin bad++; $display("[TB] FAIL rand_in_ready: cycle %0d got %b expected %b", c, in_ready, (n != DEPTH)); end
            total++; if (almost_full !== (n >= DEPTH - 1)) begin bad++; $display("[TB] FAIL rand_almost_full: cycle %0d got %b expected %b", c, almost_full, (n >= DEPTH - 1)); end
            total++; if (out_valid !== expValid) begin bad++; $display("[TB] FAIL rand_out_valid: cycle %0d got %b expected %b", c, out_valid, expValid); end
            total++; if (out_pc !== expPc || out_instr !== expInstr) begin bad++; $display("[TB] FAIL rand_out_data: cycle %0d got %0h/%0h expected %0h/%0h", c, out_pc, out_instr, expPc, expInstr); end
            tick();
        end
        setIn(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_empty_push();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifq.md
IFQ -- requirements
Module: ifq

Interface
REQ-001: Parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002: Parameter W, default 32: width of the stored PC and instruction fields.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: in_valid  input  1  the fetch stage presents a {pc, instr} pair.
REQ-006: in_pc  input  W  PC of the fetched instruction.
REQ-007: in_instr  input  W  instruction word read from instruction memory.
REQ-008: in_ready  output  1  the queue accepts a push this cycle.
REQ-009: almost_full  output  1  count >= DEPTH-1; fetch uses it to stop issuing, covering the 1-cycle instruction-memory latency.
REQ-010: out_valid  output  1  the head entry is valid for decode.
REQ-011: out_pc  output  W  PC of the head entry.
REQ-012: out_instr  output  W  instruction of the head entry.
REQ-013: out_ready  input  1  decode consumes the head this cycle.
REQ-014: flush  input  1  branch/jump redirect; discard all entries.
REQ-015: count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016: Push occurs iff in_valid && in_ready; pop occurs iff out_valid && out_ready.
REQ-017: in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready; when full, a same-cycle pop does not enable a push.
REQ-018: Storage is a circular buffer with write and read pointers; each pointer increments modulo DEPTH on its event and wraps from DEPTH-1 to 0.
REQ-019: count updates on each edge: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
REQ-020: out_valid = (count != 0); out_pc/out_instr are driven combinationally from the entry at the read pointer.
REQ-021: Entries leave in strict push order (FIFO); data of an entry never changes while it is stored.
REQ-022: When the queue is empty (non-bypass build), a pushed entry appears at the outputs on the cycle after the push (1-cycle latency).
REQ-023: While flush=1 at an edge, push and pop are both suppressed; after the edge count=0, both pointers=0, and out_valid=0.
REQ-024: flush has priority over push, pop and bypass; in_ready remains !full during the flush cycle, but the accepted data is dropped.
REQ-025: When out_valid=0, out_pc and out_instr SHALL be 0.

Reset
REQ-026: Asserting rst SHALL immediately, without a clock edge, set count=0 and both pointers=0, forcing out_valid=0, in_ready=1, almost_full=0, out_pc=0, out_instr=0.
REQ-027: Storage contents need not be reset; they SHALL be unobservable because of REQ-025.
REQ-028: rst asserted mid-operation discards all entries, with the same result as REQ-026.

Configuration
REQ-029: Macro IFQ_BYPASS_EN: if defined, when count=0 and flush=0, out_valid=in_valid and out_pc/out_instr=in_pc/in_instr combinationally. If out_ready=1 in that cycle, the entry is consumed and not stored; otherwise it is stored normally.
REQ-030: Without IFQ_BYPASS_EN, there is no combinational path from the in_* ports to the out_* ports, and minimum latency is 1 cycle.

Verification
REQ-031: After reset, push pc=0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0, almost_full=1 from count=3; then out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC, then out_valid=0.
REQ-032: Continuous push+pop at count=2 for 10 cycles (pc 0x100 upward by 4) -> count remains 2, order preserved, pointers wrap at least twice.
REQ-033: Queue full, in_valid=1, out_ready=1 -> one pop, no push, count=3, in_ready=1 on the next cycle.
REQ-034: count=3, assert flush with in_valid=1 and out_ready=1 -> count=0 and out_valid=0 after the edge; a push of 0x200 on the next cycle appears as out_pc=0x200.
REQ-035: Assert rst asynchronously between edges with count=2 -> out_valid=0 and count=0 before the next edge.
REQ-036: Empty queue, push 0x40 with out_ready=1 -> with IFQ_BYPASS_EN: out_pc=0x40 in the same cycle and count stays 0; without it: out_pc=0x40 one cycle later and count=1.
